// File: rtl/vec_alu_pipe_if.sv
// rtl/vec_alu_pipe_if.sv - valid/ready beat and result bundle for vec_alu_pipe
interface vec_alu_pipe_if #(
  parameter int LANES = 16,
  parameter int W     = 32
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           opcode;
  logic [LANES*W-1:0]   a;
  logic [LANES*W-1:0]   b;
  logic                 out_valid;
  logic                 out_ready;
  logic [LANES*W-1:0]   lo;
  logic [LANES*W-1:0]   hi;

  modport master (
    output in_valid, opcode, a, b, out_ready,
    input  in_ready, out_valid, lo, hi
  );

  modport slave (
    input  in_valid, opcode, a, b, out_ready,
    output in_ready, out_valid, lo, hi
  );
endinterface

// File: rtl/vec_alu_pipe.sv
// rtl/vec_alu_pipe.sv - two-stage multi-lane add/sub/mul pipeline with valid/ready flow control
module vec_alu_pipe #(
  parameter int LANES = 16,
  parameter int W     = 32
) (
  input logic           clk,
  input logic           rst,
  vec_alu_pipe_if.slave bus
);
  localparam int VW = LANES * W;

  logic          stall;
  logic          s1_valid;
  logic [1:0]    s1_op;
  logic [VW-1:0] s1_a;
  logic [VW-1:0] s1_b;
  logic [VW-1:0] res_lo;
  logic [VW-1:0] res_hi;
  logic          s2_valid;
  logic [VW-1:0] s2_lo;
  logic [VW-1:0] s2_hi;

  // Whole pipe freezes only when a held result is refused by the sink.
  assign stall        = s2_valid & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (!stall) begin
      s1_valid <= bus.in_valid;
      s1_op    <= bus.opcode;
      s1_a     <= bus.a;
      s1_b     <= bus.b;
    end
  end

  // opcode[1] selects multiply; opcode[0] selects sub (add/sub) or unsigned (mul).
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [W-1:0]          la;
    logic [W-1:0]          lb;
    logic [W:0]            sum;
    logic                  ext_a;
    logic                  ext_b;
    logic signed [2*W+1:0] ma;
    logic signed [2*W+1:0] mb;
    logic signed [2*W+1:0] prod;
    logic                  unused_prod_top;

    assign la  = s1_a[i*W +: W];
    assign lb  = s1_b[i*W +: W];
    assign sum = s1_op[0] ? ({la[W-1], la} - {lb[W-1], lb})
                          : ({la[W-1], la} + {lb[W-1], lb});

    // One signed multiplier serves both mul flavours: unsigned operands are
    // zero-extended, so the low 2W bits of the product are exact either way.
    assign ext_a = ~s1_op[0] & la[W-1];
    assign ext_b = ~s1_op[0] & lb[W-1];
    assign ma    = {{(W+2){ext_a}}, la};
    assign mb    = {{(W+2){ext_b}}, lb};
    assign prod  = ma * mb;
    assign unused_prod_top = ^prod[2*W+1:2*W];

    assign res_lo[i*W +: W] = s1_op[1] ? prod[W-1:0]   : sum[W-1:0];
    assign res_hi[i*W +: W] = s1_op[1] ? prod[2*W-1:W] : {W{sum[W]}};
  end

  // Result registers only change on a real beat so idle outputs keep the last result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_lo    <= '0;
      s2_hi    <= '0;
    end else if (!stall) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_lo <= res_lo;
        s2_hi <= res_hi;
      end
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.lo        = s2_lo;
  assign bus.hi        = s2_hi;
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb/tb_vec_alu_pipe.sv - scoreboard bench: 16x32 directed/stall/reset, 4x16 random
module tb_vec_alu_pipe;
  localparam int BL = 16, BW = 32, SL = 4, SW = 16;
  localparam int BV = BL * BW, SV = SL * SW;
  localparam int NRAND = 10000;
  localparam int ND = 6;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vec_alu_pipe_if #(.LANES(BL), .W(BW)) big_if ();
  vec_alu_pipe_if #(.LANES(SL), .W(SW)) small_if ();

  vec_alu_pipe #(.LANES(BL), .W(BW)) dut_big   (.clk(clk), .rst(rst), .bus(big_if));
  vec_alu_pipe #(.LANES(SL), .W(SW)) dut_small (.clk(clk), .rst(rst), .bus(small_if));

  int nvec = 0;
  int nmis = 0;
  logic [2*BV-1:0] bq[$];
  logic [2*SV-1:0] sq[$];

  int         d_lane [ND] = '{0, 3, 5, 15, 7, 2};
  logic [1:0] d_op   [ND] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
  logic [31:0] d_a   [ND] = '{32'h7FFFFFFF, 32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
  logic [31:0] d_b   [ND] = '{32'h1, 32'h1, 32'h3, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
  logic [31:0] d_lo  [ND] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFA, 32'h00000001, 32'h0, 32'h0};
  logic [31:0] d_hi  [ND] = '{32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h40000000};

  // Reference for one lane of width w (w <= 32), returned as {hi, lo} in 64-bit fields.
  function automatic logic [127:0] lane_ref(int w, logic [1:0] op, logic [63:0] a, logic [63:0] b);
    logic [63:0] mask, ua, ub, lo, hi, up;
    longint xa, xb, t;
    mask = (64'd1 << w) - 64'd1;
    ua = a & mask;
    ub = b & mask;
    xa = $signed(ua << (64 - w)) >>> (64 - w);
    xb = $signed(ub << (64 - w)) >>> (64 - w);
    case (op)
      2'd0, 2'd1: begin
        t  = (op == 2'd0) ? xa + xb : xa - xb;
        lo = t & mask;
        hi = t[w] ? mask : 64'd0;
      end
      2'd2: begin
        t  = xa * xb;
        lo = t & mask;
        hi = (t >> w) & mask;
      end
      default: begin
        up = ua * ub;
        lo = up & mask;
        hi = (up >> w) & mask;
      end
    endcase
    return {hi, lo};
  endfunction

  function automatic logic [2*BV-1:0] big_ref(logic [1:0] op, logic [BV-1:0] a, logic [BV-1:0] b);
    logic [BV-1:0] lo, hi;
    logic [127:0] r;
    for (int i = 0; i < BL; i++) begin
      r = lane_ref(BW, op, 64'(a[i*BW +: BW]), 64'(b[i*BW +: BW]));
      lo[i*BW +: BW] = r[BW-1:0];
      hi[i*BW +: BW] = r[64 +: BW];
    end
    return {hi, lo};
  endfunction

  function automatic logic [2*SV-1:0] small_ref(logic [1:0] op, logic [SV-1:0] a, logic [SV-1:0] b);
    logic [SV-1:0] lo, hi;
    logic [127:0] r;
    for (int i = 0; i < SL; i++) begin
      r = lane_ref(SW, op, 64'(a[i*SW +: SW]), 64'(b[i*SW +: SW]));
      lo[i*SW +: SW] = r[SW-1:0];
      hi[i*SW +: SW] = r[64 +: SW];
    end
    return {hi, lo};
  endfunction

  function automatic logic [BV-1:0] put_lane(int k, logic [BW-1:0] v);
    logic [BV-1:0] r;
    r = '0;
    r[k*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [BV-1:0] rand_big();
    logic [BV-1:0] r;
    for (int i = 0; i < BL; i++) r[i*BW +: BW] = $urandom;
    return r;
  endfunction

  function automatic logic [SV-1:0] rand_small();
    logic [SV-1:0] r;
    logic [SW-1:0] v;
    for (int i = 0; i < SL; i++) begin
      case ($urandom_range(0, 7))
        0:       v = '0;
        1:       v = 16'h7FFF;
        2:       v = 16'h8000;
        3:       v = '1;
        default: v = SW'($urandom);
      endcase
      r[i*SW +: SW] = v;
    end
    return r;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    big_if.in_valid = 1'b0; big_if.opcode = 2'd0; big_if.a = '0; big_if.b = '0; big_if.out_ready = 1'b1;
    small_if.in_valid = 1'b0; small_if.opcode = 2'd0; small_if.a = '0; small_if.b = '0; small_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    nvec++; if (big_if.out_valid !== 1'b0) begin nmis++; $display("FAIL rst_out_valid: got %b want 0", big_if.out_valid); end
    nvec++; if (big_if.lo !== '0) begin nmis++; $display("FAIL rst_lo: got %h want 0", big_if.lo); end
    nvec++; if (big_if.hi !== '0) begin nmis++; $display("FAIL rst_hi: got %h want 0", big_if.hi); end
    nvec++; if (small_if.out_valid !== 1'b0) begin nmis++; $display("FAIL rst_small_valid: got %b want 0", small_if.out_valid); end
    rst = 1'b0;
    #1;
    nvec++; if (big_if.in_ready !== 1'b1) begin nmis++; $display("FAIL rst_in_ready: got %b want 1", big_if.in_ready); end
  endtask

  task automatic test_directed();
    logic [2*BV-1:0] e;
    for (int k = 0; k < ND; k++) begin
      @(negedge clk);
      big_if.opcode = d_op[k];
      big_if.a = put_lane(d_lane[k], d_a[k]);
      big_if.b = put_lane(d_lane[k], d_b[k]);
      big_if.in_valid = 1'b1;
      big_if.out_ready = 1'b1;
      #1;
      nvec++; if (big_if.in_ready !== 1'b1) begin nmis++; $display("FAIL dir%0d_in_ready: got %b want 1", k, big_if.in_ready); end
      bq.push_back({put_lane(d_lane[k], d_hi[k]), put_lane(d_lane[k], d_lo[k])});
      @(negedge clk);
      big_if.in_valid = 1'b0;
      #1;
      nvec++; if (big_if.out_valid !== 1'b0) begin nmis++; $display("FAIL dir%0d_lat1: out_valid got %b want 0", k, big_if.out_valid); end
      @(negedge clk); #1;
      nvec++; if (big_if.out_valid !== 1'b1) begin nmis++; $display("FAIL dir%0d_lat2: out_valid got %b want 1", k, big_if.out_valid); end
      e = bq.pop_front();
      nvec++; if (big_if.lo !== e[BV-1:0]) begin nmis++; $display("FAIL dir%0d_lo: got %h want %h", k, big_if.lo, e[BV-1:0]); end
      nvec++; if (big_if.hi !== e[2*BV-1:BV]) begin nmis++; $display("FAIL dir%0d_hi: got %h want %h", k, big_if.hi, e[2*BV-1:BV]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] ops [3];
    logic [BV-1:0] va [3];
    logic [BV-1:0] vb [3];
    logic [2*BV-1:0] e;
    int idx = 0, got = 0, stalls = 0, last = -1;
    ops = '{2'd1, 2'd2, 2'd3};
    for (int k = 0; k < 3; k++) begin va[k] = rand_big(); vb[k] = rand_big(); end
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      big_if.in_valid = (idx < 3);
      if (idx < 3) begin big_if.opcode = ops[idx]; big_if.a = va[idx]; big_if.b = vb[idx]; end
      big_if.out_ready = (stalls >= 3);
      #1;
      if (big_if.out_valid && !big_if.out_ready) begin
        stalls++;
        nvec++; if (big_if.in_ready !== 1'b0) begin nmis++; $display("FAIL b2b_stall_in_ready: got %b want 0", big_if.in_ready); end
        e = (bq.size() > 0) ? bq[0] : '0;
        nvec++; if (big_if.lo !== e[BV-1:0]) begin nmis++; $display("FAIL b2b_hold_lo: got %h want %h", big_if.lo, e[BV-1:0]); end
        nvec++; if (big_if.hi !== e[2*BV-1:BV]) begin nmis++; $display("FAIL b2b_hold_hi: got %h want %h", big_if.hi, e[2*BV-1:BV]); end
      end
      if (big_if.out_valid && big_if.out_ready) begin
        e = (bq.size() > 0) ? bq.pop_front() : '0;
        nvec++; if (big_if.lo !== e[BV-1:0]) begin nmis++; $display("FAIL b2b_lo%0d: got %h want %h", got, big_if.lo, e[BV-1:0]); end
        nvec++; if (big_if.hi !== e[2*BV-1:BV]) begin nmis++; $display("FAIL b2b_hi%0d: got %h want %h", got, big_if.hi, e[2*BV-1:BV]); end
        if (got > 0) begin
          nvec++; if (cyc != last + 1) begin nmis++; $display("FAIL b2b_gap: delivered at cycle %0d want %0d", cyc, last + 1); end
        end
        last = cyc;
        got++;
      end
      if (big_if.in_valid && big_if.in_ready) begin
        bq.push_back(big_ref(big_if.opcode, big_if.a, big_if.b));
        idx++;
      end
    end
    big_if.in_valid = 1'b0;
    nvec++; if (got != 3) begin nmis++; $display("FAIL b2b_count: got %0d results want 3", got); end
    nvec++; if (stalls != 3) begin nmis++; $display("FAIL b2b_stalls: got %0d stall cycles want 3", stalls); end
  endtask

  task automatic test_reset_inflight();
    logic [2*BV-1:0] e;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      big_if.out_ready = 1'b0;
      big_if.in_valid = 1'b1;
      big_if.opcode = 2'd0;
      big_if.a = rand_big();
      big_if.b = rand_big();
    end
    @(negedge clk);
    rst = 1'b1;
    big_if.a = rand_big();
    #1;
    nvec++; if (big_if.out_valid !== 1'b1 || big_if.in_ready !== 1'b0) begin
      nmis++; $display("FAIL rsti_inflight: out_valid/in_ready got %b/%b want 1/0", big_if.out_valid, big_if.in_ready);
    end
    @(negedge clk); #1;
    nvec++; if (big_if.out_valid !== 1'b0) begin nmis++; $display("FAIL rsti_out_valid: got %b want 0", big_if.out_valid); end
    nvec++; if (big_if.lo !== '0) begin nmis++; $display("FAIL rsti_lo: got %h want 0", big_if.lo); end
    nvec++; if (big_if.hi !== '0) begin nmis++; $display("FAIL rsti_hi: got %h want 0", big_if.hi); end
    nvec++; if (big_if.in_ready !== 1'b1) begin nmis++; $display("FAIL rsti_in_ready: got %b want 1", big_if.in_ready); end
    @(negedge clk);
    rst = 1'b0;
    big_if.in_valid = 1'b0;
    big_if.out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      #1;
      nvec++; if (big_if.out_valid !== 1'b0) begin nmis++; $display("FAIL rsti_ghost%0d: out_valid got %b want 0", c, big_if.out_valid); end
      @(negedge clk);
    end
    big_if.in_valid = 1'b1;
    big_if.opcode = 2'd3;
    big_if.a = rand_big();
    big_if.b = rand_big();
    #1;
    bq.push_back(big_ref(big_if.opcode, big_if.a, big_if.b));
    @(negedge clk);
    big_if.in_valid = 1'b0;
    #1;
    nvec++; if (big_if.out_valid !== 1'b0) begin nmis++; $display("FAIL rsti_first_lat1: got %b want 0", big_if.out_valid); end
    @(negedge clk); #1;
    nvec++; if (big_if.out_valid !== 1'b1) begin nmis++; $display("FAIL rsti_first_lat2: got %b want 1", big_if.out_valid); end
    e = bq.pop_front();
    nvec++; if (big_if.lo !== e[BV-1:0]) begin nmis++; $display("FAIL rsti_first_lo: got %h want %h", big_if.lo, e[BV-1:0]); end
    nvec++; if (big_if.hi !== e[2*BV-1:BV]) begin nmis++; $display("FAIL rsti_first_hi: got %h want %h", big_if.hi, e[2*BV-1:BV]); end
  endtask

  task automatic test_random();
    int acc = 0, del = 0, cyc = 0;
    logic pend = 1'b0;
    logic [2*SV-1:0] e;
    while (del < NRAND && cyc < 50000) begin
      @(negedge clk);
      cyc++;
      if (!pend && acc < NRAND && $urandom_range(0, 3) != 0) begin
        small_if.opcode = 2'($urandom_range(0, 3));
        small_if.a = rand_small();
        small_if.b = rand_small();
        pend = 1'b1;
      end
      small_if.in_valid = pend;
      small_if.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (small_if.out_valid && small_if.out_ready) begin
        nvec++;
        if (sq.size() == 0) begin
          nmis++; $display("FAIL rnd_unexpected: result %h with empty scoreboard", {small_if.hi, small_if.lo});
        end else begin
          e = sq.pop_front();
          if ({small_if.hi, small_if.lo} !== e) begin
            nmis++; $display("FAIL rnd_result%0d: got %h want %h", del, {small_if.hi, small_if.lo}, e);
          end
        end
        del++;
      end else if (small_if.out_valid) begin
        nvec++; if (small_if.in_ready !== 1'b0) begin nmis++; $display("FAIL rnd_stall_ready: got %b want 0", small_if.in_ready); end
      end else begin
        nvec++; if ($isunknown({small_if.hi, small_if.lo})) begin nmis++; $display("FAIL rnd_idle_known: got %h want known", {small_if.hi, small_if.lo}); end
      end
      if (small_if.in_valid && small_if.in_ready) begin
        sq.push_back(small_ref(small_if.opcode, small_if.a, small_if.b));
        pend = 1'b0;
        acc++;
      end
    end
    small_if.in_valid = 1'b0;
    nvec++; if (del != NRAND) begin nmis++; $display("FAIL rnd_timeout: delivered %0d want %0d", del, NRAND); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_inflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
